// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_pkg
//  Description : Shared types, constants and helpers for the programmable
//                clock divider (clk_div_prog) and its bench.
//  Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    // Output behaviour of the divider
    typedef enum logic {
        CLK_MODE   = 1'b0,
        PULSE_MODE = 1'b1
    } div_mode_e;

    // Smallest divisor the counter supports; smaller requests are raised to it
    localparam logic [31:0] MIN_DIV = 32'd2;

    // Raise divisor requests of 0 and 1 to MIN_DIV; larger values pass through
    function automatic logic [31:0] clamp_div(input logic [31:0] div_val);
        return (div_val < MIN_DIV) ? MIN_DIV : div_val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_cfg_reg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_cfg_reg
//  Description : Holds the pending divisor and the active divisor/mode, and
//                swaps the pending value in only when the caller flags a
//                period boundary. Also exposes the values that will govern
//                the period starting on the current edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_div_cfg_reg
    import clk_div_pkg::*;
#(
    parameter int          CNT_W        = 8,
    parameter int unsigned DEFAULT_DIV  = 2,
    parameter bit          DEFAULT_MODE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,        // asynchronous, active-low
    input  logic             apply,      // this edge is a period boundary
    input  logic             mode,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_val,
    output logic             div_busy,
    output logic [CNT_W-1:0] div_cur,
    output logic             mode_cur,
    output logic [CNT_W-1:0] div_nx,     // divisor in force after this edge
    output logic             mode_nx     // mode in force after this edge
);

    logic             r_pend;
    logic [CNT_W-1:0] r_pend_val;
    logic [CNT_W-1:0] r_div_cur;
    div_mode_e        r_mode_cur;
    logic [CNT_W-1:0] w_div_clamped;

    assign w_div_clamped = CNT_W'(clamp_div(32'(div_val)));

    // A boundary adopts the pending divisor (if any) and the requested mode
    assign div_nx   = (apply && r_pend) ? r_pend_val : r_div_cur;
    assign mode_nx  = apply ? mode : r_mode_cur;

    assign div_busy = r_pend;
    assign div_cur  = r_div_cur;
    assign mode_cur = r_mode_cur;

    // Pending capture and boundary apply; a load on a boundary edge stays pending
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend     <= 1'b0;
            r_pend_val <= CNT_W'(DEFAULT_DIV);
            r_div_cur  <= CNT_W'(DEFAULT_DIV);
            r_mode_cur <= div_mode_e'(DEFAULT_MODE);
        end else begin
            if (apply) begin
                r_div_cur  <= div_nx;
                r_mode_cur <= div_mode_e'(mode_nx);
            end
            if (div_load) begin
                r_pend     <= 1'b1;
                r_pend_val <= w_div_clamped;
            end else if (apply) begin
                r_pend     <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_prog
//  Description : Runtime-programmable clock divider. Produces a square
//                divided clock or a one-cycle period pulse, plus a per-period
//                tick. Divisor and mode changes land only on period
//                boundaries so the output never glitches.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int          CNT_W        = 8,
    parameter int unsigned DEFAULT_DIV  = 2,
    parameter bit          DEFAULT_MODE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,        // asynchronous, active-low
    input  logic             en,
    input  logic             mode,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_val,
    output logic             div_busy,
    output logic [CNT_W-1:0] div_cur,
    output logic             clk_d,
    output logic             tick
);

    logic             r_running;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clk_d;
    logic             r_tick;

    logic             w_wrap;
    logic             w_apply;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [CNT_W-1:0] w_div_nx;
    logic             w_mode_nx;
    logic             w_mode_cur;
    logic [CNT_W:0]   w_high_len;
    logic             w_clk_d_nx;
    logic             w_tick_nx;

    // Last count of the period; the edge leaving it starts a new period
    assign w_wrap  = r_running && (r_cnt == (div_cur - 1'b1));

    // Idle, start and wrap edges all let new configuration take effect
    assign w_apply = !en || !r_running || w_wrap;

    clk_div_cfg_reg #(
        .CNT_W        (CNT_W),
        .DEFAULT_DIV  (DEFAULT_DIV),
        .DEFAULT_MODE (DEFAULT_MODE)
    ) u_cfg (
        .clk      (clk),
        .rst      (rst),
        .apply    (w_apply),
        .mode     (mode),
        .div_load (div_load),
        .div_val  (div_val),
        .div_busy (div_busy),
        .div_cur  (div_cur),
        .mode_cur (w_mode_cur),
        .div_nx   (w_div_nx),
        .mode_nx  (w_mode_nx)
    );

    // Next count: held at zero when idle or starting, otherwise wraps at div_cur
    always_comb begin
        w_cnt_nx = '0;
        if (en && r_running && !w_wrap) begin
            w_cnt_nx = r_cnt + 1'b1;
        end
    end

    // Square wave stays high for ceil(N/2) counts; extra bit avoids overflow at max N
    assign w_high_len = ({1'b0, w_div_nx} + 1'b1) >> 1;
    assign w_clk_d_nx = en && ((div_mode_e'(w_mode_nx) == PULSE_MODE)
                               ? (w_cnt_nx == '0)
                               : ({1'b0, w_cnt_nx} < w_high_len));
    assign w_tick_nx  = en && (w_cnt_nx == '0);

    // Period counter, run flag and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_running <= 1'b0;
            r_cnt     <= '0;
            r_clk_d   <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_running <= en;
            r_cnt     <= w_cnt_nx;
            r_clk_d   <= w_clk_d_nx;
            r_tick    <= w_tick_nx;
        end
    end

    assign clk_d = r_clk_d;
    assign tick  = r_tick;

    // Active mode is only observed through the next-mode path
    logic w_unused;
    assign w_unused = w_mode_cur;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_prog.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_div_prog
//  Description : Directed self-checking bench for clk_div_prog (DEFAULT_DIV=4,
//                CLOCK mode after reset).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_prog;
    import clk_div_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       mode;
    logic       div_load;
    logic [7:0] div_val;
    logic       div_busy;
    logic [7:0] div_cur;
    logic       clk_d;
    logic       tick;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    clk_div_prog #(
        .CNT_W        (8),
        .DEFAULT_DIV  (4),
        .DEFAULT_MODE (1'b0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .div_load (div_load),
        .div_val  (div_val),
        .div_busy (div_busy),
        .div_cur  (div_cur),
        .clk_d    (clk_d),
        .tick     (tick)
    );

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Shift in clk_d/tick over n edges, first edge ends up most significant
    task automatic collect(input int n, output logic [31:0] cd, output logic [31:0] tk);
        cd = '0;
        tk = '0;
        for (int i = 0; i < n; i++) begin
            step();
            cd = {cd[30:0], clk_d};
            tk = {tk[30:0], tick};
        end
    endtask

    // Step until the first edge of a new period (bounded)
    task automatic wait_boundary();
        int k;
        k = 0;
        step();
        while (tick !== 1'b1 && k < 64) begin
            step();
            k++;
        end
        n_tests++;
        if (tick !== 1'b1) begin
            n_fail++;
            $display("FAIL boundary_timeout: tick=%b required 1", tick);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; mode = 1'b0; div_load = 1'b0; div_val = 8'd0;
        #12;
        n_tests++; if (clk_d !== 1'b0)  begin n_fail++; $display("FAIL reset_clk_d: got %b required 0", clk_d); end
        n_tests++; if (tick !== 1'b0)   begin n_fail++; $display("FAIL reset_tick: got %b required 0", tick); end
        n_tests++; if (div_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", div_busy); end
        n_tests++; if (div_cur !== 8'd4) begin n_fail++; $display("FAIL reset_div_cur: got %0d required 4", div_cur); end
        rst = 1'b1;
        step(); step();
        n_tests++; if (clk_d !== 1'b0)  begin n_fail++; $display("FAIL idle_clk_d: got %b required 0", clk_d); end
    endtask

    task automatic test_clock_div4();
        logic [31:0] cd, tk;
        en = 1'b1;
        collect(8, cd, tk);
        n_tests++; if (cd[7:0] !== 8'b11001100) begin n_fail++; $display("FAIL div4_clk_d: got %b required 11001100", cd[7:0]); end
        n_tests++; if (tk[7:0] !== 8'b10001000) begin n_fail++; $display("FAIL div4_tick: got %b required 10001000", tk[7:0]); end
    endtask

    task automatic test_load_mid();
        logic [31:0] cd, tk;
        step();                                   // cnt 0
        div_load = 1'b1; div_val = 8'd5;
        step();                                   // cnt 1, load captured
        div_load = 1'b0;
        n_tests++; if (div_busy !== 1'b1) begin n_fail++; $display("FAIL load5_busy: got %b required 1", div_busy); end
        n_tests++; if (div_cur !== 8'd4)  begin n_fail++; $display("FAIL load5_cur_before: got %0d required 4", div_cur); end
        step(); step();                           // cnt 3
        n_tests++; if (div_busy !== 1'b1) begin n_fail++; $display("FAIL load5_busy_hold: got %b required 1", div_busy); end
        collect(10, cd, tk);
        n_tests++; if (cd[9:0] !== 10'b1110011100) begin n_fail++; $display("FAIL div5_clk_d: got %b required 1110011100", cd[9:0]); end
        n_tests++; if (tk[9:0] !== 10'b1000010000) begin n_fail++; $display("FAIL div5_tick: got %b required 1000010000", tk[9:0]); end
        n_tests++; if (div_cur !== 8'd5)  begin n_fail++; $display("FAIL load5_cur_after: got %0d required 5", div_cur); end
        n_tests++; if (div_busy !== 1'b0) begin n_fail++; $display("FAIL load5_busy_clear: got %b required 0", div_busy); end
    endtask

    task automatic test_clamp();
        logic [31:0] cd, tk;
        step();                                   // boundary, cnt 0
        div_load = 1'b1; div_val = 8'd0;
        step();
        div_load = 1'b0;
        wait_boundary();
        n_tests++; if (div_cur !== 8'd2) begin n_fail++; $display("FAIL clamp0_cur: got %0d required 2", div_cur); end
        collect(6, cd, tk);
        n_tests++; if (cd[5:0] !== 6'b010101) begin n_fail++; $display("FAIL clamp0_clk_d: got %b required 010101", cd[5:0]); end
        n_tests++; if (tk[5:0] !== 6'b010101) begin n_fail++; $display("FAIL clamp0_tick: got %b required 010101", tk[5:0]); end
        div_load = 1'b1; div_val = 8'd1;
        step();                                   // cnt 1, not a boundary
        div_load = 1'b0;
        n_tests++; if (div_busy !== 1'b1) begin n_fail++; $display("FAIL clamp1_busy: got %b required 1", div_busy); end
        step();                                   // boundary applies clamp(1)
        n_tests++; if (div_cur !== 8'd2)  begin n_fail++; $display("FAIL clamp1_cur: got %0d required 2", div_cur); end
        n_tests++; if (div_busy !== 1'b0) begin n_fail++; $display("FAIL clamp1_busy_clear: got %b required 0", div_busy); end
        collect(4, cd, tk);
        n_tests++; if (cd[3:0] !== 4'b0101) begin n_fail++; $display("FAIL clamp1_clk_d: got %b required 0101", cd[3:0]); end
    endtask

    task automatic test_pulse_mode();
        logic [31:0] cd, tk;
        div_load = 1'b1; div_val = 8'd3;
        step();                                   // cnt 1, not a boundary
        div_load = 1'b0;
        wait_boundary();
        n_tests++; if (div_cur !== 8'd3) begin n_fail++; $display("FAIL div3_cur: got %0d required 3", div_cur); end
        mode = PULSE_MODE;
        // First period still square (110 phase from cnt 1), pulse from next boundary
        collect(9, cd, tk);
        n_tests++; if (cd[8:0] !== 9'b101001001) begin n_fail++; $display("FAIL pulse_clk_d: got %b required 101001001", cd[8:0]); end
        n_tests++; if (tk[8:0] !== 9'b001001001) begin n_fail++; $display("FAIL pulse_tick: got %b required 001001001", tk[8:0]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] cd, tk;
        div_load = 1'b1; div_val = 8'd6;
        step();                                   // cnt 1
        div_val = 8'd7;
        step();                                   // cnt 2, overwrite
        div_load = 1'b0;
        n_tests++; if (div_cur !== 8'd3)  begin n_fail++; $display("FAIL b2b_cur_before: got %0d required 3", div_cur); end
        step();                                   // boundary
        n_tests++; if (div_cur !== 8'd7)  begin n_fail++; $display("FAIL b2b_cur: got %0d required 7", div_cur); end
        n_tests++; if (div_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy: got %b required 0", div_busy); end
        collect(7, cd, tk);
        n_tests++; if (tk[6:0] !== 7'b0000001) begin n_fail++; $display("FAIL div7_tick: got %b required 0000001", tk[6:0]); end
        for (int i = 0; i < 5; i++) step();       // cnt 5
        div_load = 1'b1; div_val = 8'd5;
        step();                                   // cnt 6, pending 5
        div_val = 8'd4;
        step();                                   // boundary: 5 applied, 4 pending
        div_load = 1'b0;
        n_tests++; if (div_cur !== 8'd5)  begin n_fail++; $display("FAIL bnd_load_cur: got %0d required 5", div_cur); end
        n_tests++; if (div_busy !== 1'b1) begin n_fail++; $display("FAIL bnd_load_busy: got %b required 1", div_busy); end
        wait_boundary();
        n_tests++; if (div_cur !== 8'd4)  begin n_fail++; $display("FAIL bnd_load_next: got %0d required 4", div_cur); end
        n_tests++; if (div_busy !== 1'b0) begin n_fail++; $display("FAIL bnd_load_clear: got %b required 0", div_busy); end
    endtask

    task automatic test_idle_and_reset();
        logic [31:0] cd, tk;
        mode = CLK_MODE;
        wait_boundary();                          // CLOCK mode, div 4
        step();                                   // cnt 1
        n_tests++; if (clk_d !== 1'b1) begin n_fail++; $display("FAIL pre_idle_clk_d: got %b required 1", clk_d); end
        en = 1'b0;
        step();
        n_tests++; if (clk_d !== 1'b0 || tick !== 1'b0) begin n_fail++; $display("FAIL idle_outputs: got clk_d=%b tick=%b required 0 0", clk_d, tick); end
        div_load = 1'b1; div_val = 8'd9;
        step();
        div_load = 1'b0;
        n_tests++; if (div_busy !== 1'b1 || div_cur !== 8'd4) begin n_fail++; $display("FAIL idle_load: got busy=%b cur=%0d required 1 4", div_busy, div_cur); end
        step();
        n_tests++; if (div_busy !== 1'b0 || div_cur !== 8'd9) begin n_fail++; $display("FAIL idle_apply: got busy=%b cur=%0d required 0 9", div_busy, div_cur); end
        en = 1'b1;
        step();
        n_tests++; if (clk_d !== 1'b1 || tick !== 1'b1) begin n_fail++; $display("FAIL restart: got clk_d=%b tick=%b required 1 1", clk_d, tick); end
        step(); step();                           // cnt 2, still high
        rst = 1'b0;
        #2;
        n_tests++; if (clk_d !== 1'b0 || tick !== 1'b0) begin n_fail++; $display("FAIL async_rst_out: got clk_d=%b tick=%b required 0 0", clk_d, tick); end
        n_tests++; if (div_cur !== 8'd4 || div_busy !== 1'b0) begin n_fail++; $display("FAIL async_rst_cfg: got cur=%0d busy=%b required 4 0", div_cur, div_busy); end
        #10;
        rst = 1'b1;
        collect(4, cd, tk);
        n_tests++; if (cd[3:0] !== 4'b1100) begin n_fail++; $display("FAIL post_rst_clk_d: got %b required 1100", cd[3:0]); end
        n_tests++; if (tk[3:0] !== 4'b1000) begin n_fail++; $display("FAIL post_rst_tick: got %b required 1000", tk[3:0]); end
    endtask

    initial begin
        test_reset();
        test_clock_div4();
        test_load_mid();
        test_clamp();
        test_pulse_mode();
        test_back_to_back();
        test_idle_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
